i_decode: RTL
=============

Name: i_decode

Overview:
- Decode stage directly downstream of instruction fetch. Consumes IF_ID_INSTR / IF_ID_NPC.
- Contains the 32x32 register file, the control decoder, the sign extender, load-use hazard detection and the ID/EX pipeline register.
- Drives the execute stage.
- Returns STALL to fetch, which holds the PC and IF/ID.

Parameters:
RF_RESET_VAL, 32'h0000_0000, value loaded into registers 1..31 on reset; register 0 is always zero.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
IF_ID_INSTR  input  32  instruction from IF/ID
IF_ID_NPC  input  32  next-PC from IF/ID
EX_MEM_PCSrc  input  1  branch taken in MEM; flush ID
MEM_WB_REGWRITE  input  1  write-back enable
MEM_WB_WRITEREG  input  5  write-back register
MEM_WB_WRITEDATA  input  32  write-back data
STALL  output  1  combinational; 1 = fetch must hold PC and IF/ID
ID_EX_WB  output  2  {RegWrite, MemtoReg}
ID_EX_M  output  3  {Branch, MemRead, MemWrite}
ID_EX_EX  output  4  {RegDst, ALUOp[1:0], ALUSrc}
ID_EX_NPC  output  32  registered IF_ID_NPC
ID_EX_RD1  output  32  rs read data
ID_EX_RD2  output  32  rt read data
ID_EX_IMM  output  32  sign-extended instr[15:0]
ID_EX_RS, ID_EX_RT, ID_EX_RD  output  5 each  instr[25:21], [20:16], [15:11]

Behaviour:
- Reset:
  - All ID_EX_* outputs are 0.
  - Registers 1..31 load RF_RESET_VAL.
  - Reset overrides writeback in the same cycle.
- Latency: one cycle from IF_ID_* to ID_EX_*.
- Decode by opcode instr[31:26]. Control shown as WB | M | EX:
  - 0x00 R-type: 10 | 000 | 1,10,0
  - 0x23 lw: 11 | 010 | 0,00,1
  - 0x2B sw: 00 | 001 | 0,00,1
  - 0x04 beq: 00 | 100 | 0,01,0
  - Any other opcode: all control bits 0 (bubble). Data fields are still latched.
- Sign extension: ID_EX_IMM = {{16{instr[15]}}, instr[15:0]}.
- Register file:
  - Write on the rising edge when MEM_WB_REGWRITE=1 and MEM_WB_WRITEREG!=0.
  - Writes to register 0 are ignored.
  - Register 0 always reads as 0.
  - Reads are asynchronous.
- Load-use hazard. STALL=1 when ID_EX_M[1]=1 (MemRead), ID_EX_RT!=0, and either:
  - ID_EX_RT==rs, or
  - ID_EX_RT==rt and the current opcode is R-type, sw or beq.
- On stall:
  - ID/EX control fields load 0 (bubble).
  - The IF/ID contents are presented again next cycle by the held fetch stage.
- Flush: EX_MEM_PCSrc=1 loads ID/EX control fields with 0 and forces STALL=0.
- Flush and stall in the same cycle: flush wins, STALL=0.
- A back-to-back load-use stall lasts exactly one cycle. The bubble clears ID_EX_M[1], so the second cycle proceeds.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass. If MEM_WB_REGWRITE=1, MEM_WB_WRITEREG!=0 and MEM_WB_WRITEREG equals rs (or rt), RD1 (or RD2) takes MEM_WB_WRITEDATA in the same cycle.
- Undefined: reads return the pre-write register value. Software must separate dependent instructions by 3 slots.

Test Plan:
- Reset: assert rst for 2 cycles with IF_ID_INSTR=32'h8C22_0004 -> all ID_EX_* = 0 and STALL=0; reading $5 afterwards gives RF_RESET_VAL.
- Write then read: write 32'hDEAD_BEEF to $3, then decode 32'h0062_2020 (add $4,$3,$2) -> next cycle ID_EX_RD1=32'hDEAD_BEEF, ID_EX_WB=2'b10, ID_EX_EX=4'b1100, ID_EX_RD=4.
- Immediate and $0: decode 32'h8C02_FFFC (lw $2,-4($0)) -> ID_EX_IMM=32'hFFFF_FFFC, ID_EX_RD1=0, ID_EX_M=3'b010; a write of 5 to $0 leaves $0 reading 0.
- Load-use: lw $2,0($1) followed by add $4,$2,$3 -> STALL=1 for exactly one cycle, bubble (all control 0) in ID/EX, the add issues the following cycle.
- Flush priority: EX_MEM_PCSrc=1 during a load-use condition -> STALL=0 and ID_EX control = 0.
- Bypass: same-cycle write of 32'h1234_5678 to $7 while decoding a read of $7 -> ID_EX_RD1=32'h1234_5678 with REGFILE_BYPASS_EN defined, the old value without it.

Source files
------------

// File: rtl/i_decode.sv
// Decode stage: register file, control decoder, sign extender, load-use hazard
// detection and the ID/EX pipeline register. Optional macro: REGFILE_BYPASS_EN.
module i_decode #(
  parameter logic [31:0] RF_RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_INSTR,
  input  logic [31:0] IF_ID_NPC,
  input  logic        EX_MEM_PCSrc,
  input  logic        MEM_WB_REGWRITE,
  input  logic [4:0]  MEM_WB_WRITEREG,
  input  logic [31:0] MEM_WB_WRITEDATA,
  output logic        STALL,
  output logic [1:0]  ID_EX_WB,
  output logic [2:0]  ID_EX_M,
  output logic [3:0]  ID_EX_EX,
  output logic [31:0] ID_EX_NPC,
  output logic [31:0] ID_EX_RD1,
  output logic [31:0] ID_EX_RD2,
  output logic [31:0] ID_EX_IMM,
  output logic [4:0]  ID_EX_RS,
  output logic [4:0]  ID_EX_RT,
  output logic [4:0]  ID_EX_RD
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;
  ctrl_t       ctrl;
  logic        uses_rt;
  logic [31:0] rd1, rd2;
  logic        load_use;
  logic        bubble;
  logic        wr_en;
  logic [31:0] regs [32];

  assign opcode = IF_ID_INSTR[31:26];
  assign rs     = IF_ID_INSTR[25:21];
  assign rt     = IF_ID_INSTR[20:16];
  assign rd     = IF_ID_INSTR[15:11];
  assign imm    = {{16{IF_ID_INSTR[15]}}, IF_ID_INSTR[15:0]};

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin ctrl = '{wb: 2'b10, m: 3'b000, ex: 4'b1100}; uses_rt = 1'b1; end
      OP_LW:          ctrl = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
      OP_SW:    begin ctrl = '{wb: 2'b00, m: 3'b001, ex: 4'b0001}; uses_rt = 1'b1; end
      OP_BEQ:   begin ctrl = '{wb: 2'b00, m: 3'b100, ex: 4'b0010}; uses_rt = 1'b1; end
      default:  ctrl = '0;
    endcase
  end

  assign wr_en = MEM_WB_REGWRITE && (MEM_WB_WRITEREG != 5'd0);

  // NOTE: the register file is reset explicitly, so it maps to flops, not RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 0) ? 32'h0 : RF_RESET_VAL;
    end else if (wr_en) begin
      regs[MEM_WB_WRITEREG] <= MEM_WB_WRITEDATA;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd1 = (rs == 5'd0) ? 32'h0 : regs[rs];
    rd2 = (rt == 5'd0) ? 32'h0 : regs[rt];
    if (wr_en && MEM_WB_WRITEREG == rs) rd1 = MEM_WB_WRITEDATA;
    if (wr_en && MEM_WB_WRITEREG == rt) rd2 = MEM_WB_WRITEDATA;
  end
`else
  assign rd1 = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign rd2 = (rt == 5'd0) ? 32'h0 : regs[rt];
`endif

  // rt only counts as a source for opcodes that actually read it.
  assign load_use = ID_EX_M[1] && (ID_EX_RT != 5'd0) &&
                    ((ID_EX_RT == rs) || (uses_rt && ID_EX_RT == rt));
  assign STALL    = load_use && !EX_MEM_PCSrc;
  assign bubble   = load_use || EX_MEM_PCSrc;

  always_ff @(posedge clk) begin
    if (rst) begin
      ID_EX_WB  <= '0;
      ID_EX_M   <= '0;
      ID_EX_EX  <= '0;
      ID_EX_NPC <= '0;
      ID_EX_RD1 <= '0;
      ID_EX_RD2 <= '0;
      ID_EX_IMM <= '0;
      ID_EX_RS  <= '0;
      ID_EX_RT  <= '0;
      ID_EX_RD  <= '0;
    end else begin
      ID_EX_WB  <= bubble ? 2'b0 : ctrl.wb;
      ID_EX_M   <= bubble ? 3'b0 : ctrl.m;
      ID_EX_EX  <= bubble ? 4'b0 : ctrl.ex;
      ID_EX_NPC <= IF_ID_NPC;
      ID_EX_RD1 <= rd1;
      ID_EX_RD2 <= rd2;
      ID_EX_IMM <= imm;
      ID_EX_RS  <= rs;
      ID_EX_RT  <= rt;
      ID_EX_RD  <= rd;
    end
  end

endmodule
